pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage core (F/D/E/M/W, 12-bit PC, 17-bit instructions).
- Produces stall, flush and forwarding controls for the Fetch, Decode, Execute and Memory stage registers.
- Sequences multi-cycle data-memory waits and a halt-drain-stop sequence.
- Sits beside the datapath; consumes register addresses and control bits from the D/E/M/W stage registers.

Parameters:
REG_W, 4, register-address width (16 architectural regs, reg 0 hard-wired zero)
CNT_W, 8, width of wait/drain counter
MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before fault (must fit CNT_W)
DRAIN_CYCLES, 3, cycles to empty E/M/W after halt leaves D

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
Rs1D  in  REG_W  source 1 of instr in D
Rs2D  in  REG_W  source 2 of instr in D
Rs1E  in  REG_W  source 1 of instr in E
Rs2E  in  REG_W  source 2 of instr in E
RdE  in  REG_W  dest of instr in E
ResultSrcE0  in  1  instr in E is a load
RdM  in  REG_W  dest of instr in M
RegWriteM  in  1  instr in M writes RF
RdW  in  REG_W  dest of instr in W
RegWriteW  in  1  instr in W writes RF
PCSrcE  in  1  taken branch/jump resolved in E
MemReqM  in  1  instr in M accesses data memory
MemReadyM  in  1  data memory completes this cycle
HaltD  in  1  instr in D is HALT
StallF  out  1  hold PC
StallD  out  1  hold F/D register
StallE  out  1  hold D/E register
StallM  out  1  hold E/M register
FlushD  out  1  clear F/D register
FlushE  out  1  clear D/E register
ForwardAE  out  2  ALU A select: 00 RF, 01 W result, 10 M ALU result
ForwardBE  out  2  ALU B select, same encoding
Halted  out  1  core stopped
MemTimeout  out  1  sticky memory-timeout fault

Behaviour:
- FSM states: RUN, DRAIN, HALTED. Counter cnt (CNT_W); timeout flag.
- Reset (reset=1 at edge): state=RUN, cnt=0, MemTimeout=0. While reset is high, outputs are forced: FlushD=FlushE=1, all Stall*=0, Forward*=00, Halted=0. Reset mid-wait or mid-drain aborts to RUN.
- All Stall/Flush/Forward outputs are combinational from state and inputs (zero latency). Only state, cnt and MemTimeout are registered.
- Forwarding (all states), shown for A; B is identical using Rs2E:
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Else 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Else 00. M has priority over W.
- Signal definitions:
  - memStall = MemReqM && !MemReadyM.
  - lwStall = ResultSrcE0 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- RUN, priority from highest to lowest:
  1. memStall: StallF=StallD=StallE=StallM=1, no flushes, PCSrcE ignored (held in E). cnt increments each memStall cycle. If cnt==MEM_TIMEOUT-1 while memStall: MemTimeout<=1, state<=HALTED. The cycle with MemReadyM=1 or MemReqM=0 clears cnt to 0 and applies the normal rules.
  2. PCSrcE: FlushD=FlushE=1, no stalls. This suppresses lwStall and HaltD in the same cycle, since both are on the wrong path.
  3. lwStall: StallF=StallD=1, FlushE=1.
  4. HaltD: StallF=1, FlushD=1. Next state DRAIN, cnt<=0. An instruction in D that is stalled by lwStall is not yet accepted as a halt.
- DRAIN:
  - StallF=1, FlushD=1 every cycle.
  - memStall behaves as in RUN (all stalls, timeout counting) and freezes drain progress.
  - Otherwise cnt increments; when cnt==DRAIN_CYCLES-1, state<=HALTED.
- HALTED: StallF=StallD=StallE=StallM=1, flushes 0, Halted=1. Exits only on reset.
- Equality comparisons are exact REG_W-bit compares. Counter never wraps (bounded by MEM_TIMEOUT).

Test Plan:
- Reset held 2 cycles, then released with all inputs 0 -> during reset FlushD=FlushE=1, Stall*=0; after reset all outputs 0, Halted=0, MemTimeout=0.
- Forwarding: Rs1E=3, RdM=3, RegWriteM=1, RdW=3, RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> 01. Set RdM=RdW=0 -> 00.
- Load-use vs branch:
  - ResultSrcE0=1, RdE=5, Rs2D=5 -> StallF=StallD=1, FlushE=1.
  - Same plus PCSrcE=1 -> FlushD=FlushE=1, StallF=StallD=0.
- Memory wait: MemReqM=1, MemReadyM=0 for 4 cycles, then MemReadyM=1 -> all four stalls high for exactly 4 cycles, low on cycle 5, no timeout.
- Timeout: MemReqM=1, MemReadyM=0 held with MEM_TIMEOUT=8 -> MemTimeout=1 and Halted=1 after 8 stall cycles. Both persist until reset, which clears them.
- Halt:
  - HaltD=1 for 1 cycle -> StallF=FlushD=1 for 1+DRAIN_CYCLES cycles, then Halted=1 with all stalls high.
  - Inject memStall for 2 cycles during DRAIN -> Halted is delayed by exactly 2 cycles.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central hazard/pipeline controller for the 5-stage core. Produces stall,
//   flush and forwarding selects for the F/D/E/M stage registers, sequences
//   multi-cycle data-memory waits (with a sticky timeout fault) and a
//   halt -> drain -> stop sequence.
//
// Ports
//   clk, reset                       clock; synchronous active-high reset
//   Rs1D, Rs2D                       sources of the instruction in D
//   Rs1E, Rs2E, RdE, ResultSrcE0     sources/dest/load flag of the instruction in E
//   RdM, RegWriteM                   dest/write-enable of the instruction in M
//   RdW, RegWriteW                   dest/write-enable of the instruction in W
//   PCSrcE                           taken branch/jump resolved in E
//   MemReqM, MemReadyM               data-memory request / completion in M
//   HaltD                            instruction in D is HALT
//   StallF/D/E/M, FlushD/E           stage-register hold / clear controls
//   ForwardAE, ForwardBE             ALU operand select: 00 RF, 01 W, 10 M
//   Halted                           core stopped
//   MemTimeout                       sticky memory-timeout fault
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_W        = 4,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] Rs1E,
  input  logic [REG_W-1:0] Rs2E,
  input  logic [REG_W-1:0] RdE,
  input  logic             ResultSrcE0,
  input  logic [REG_W-1:0] RdM,
  input  logic             RegWriteM,
  input  logic [REG_W-1:0] RdW,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic             HaltD,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             Halted,
  output logic             MemTimeout
);

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StHalted
  } state_e;

  state_e           stateQ, stateD;
  // cnt tracks consecutive memory-wait cycles; drain progress has its own
  // counter so a memory wait inside DRAIN freezes, rather than resets, it.
  logic [CNT_W-1:0] cntQ, cntD;
  logic [CNT_W-1:0] drainCntQ, drainCntD;
  logic             timeoutQ, timeoutD;

  logic memStall;
  logic lwStall;
  logic memLast;
  logic drainLast;

  assign memStall  = MemReqM && !MemReadyM;
  assign lwStall   = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign memLast   = (cntQ == CNT_W'(MEM_TIMEOUT - 1));
  assign drainLast = (drainCntQ == CNT_W'(DRAIN_CYCLES - 1));

  assign MemTimeout = timeoutQ;

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    Halted    = 1'b0;
    stateD    = stateQ;
    cntD      = cntQ;
    drainCntD = drainCntQ;
    timeoutD  = timeoutQ;

    if (reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      // Forwarding is independent of controller state; M beats W.
      if (RegWriteM && (RdM != '0) && (RdM == Rs1E)) begin
        ForwardAE = 2'b10;
      end else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) begin
        ForwardAE = 2'b01;
      end
      if (RegWriteM && (RdM != '0) && (RdM == Rs2E)) begin
        ForwardBE = 2'b10;
      end else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) begin
        ForwardBE = 2'b01;
      end

      unique case (stateQ)
        StRun: begin
          if (memStall) begin
            // Whole pipe frozen; a pending redirect stays held in E.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            if (memLast) begin
              timeoutD = 1'b1;
              stateD   = StHalted;
            end else begin
              cntD = cntQ + CNT_W'(1);
            end
          end else begin
            cntD = '0;
            if (PCSrcE) begin
              // Load-use and halt in D are on the wrong path here.
              FlushD = 1'b1;
              FlushE = 1'b1;
            end else if (lwStall) begin
              StallF = 1'b1;
              StallD = 1'b1;
              FlushE = 1'b1;
            end else if (HaltD) begin
              StallF    = 1'b1;
              FlushD    = 1'b1;
              stateD    = StDrain;
              drainCntD = '0;
            end
          end
        end

        StDrain: begin
          StallF = 1'b1;
          FlushD = 1'b1;
          if (memStall) begin
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            if (memLast) begin
              timeoutD = 1'b1;
              stateD   = StHalted;
            end else begin
              cntD = cntQ + CNT_W'(1);
            end
          end else begin
            cntD = '0;
            if (drainLast) begin
              stateD = StHalted;
            end else begin
              drainCntD = drainCntQ + CNT_W'(1);
            end
          end
        end

        StHalted: begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          StallM = 1'b1;
          Halted = 1'b1;
        end

        default: begin
          stateD = StRun;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ    <= StRun;
      cntQ      <= '0;
      drainCntQ <= '0;
      timeoutQ  <= 1'b0;
    end else begin
      stateQ    <= stateD;
      cntQ      <= cntD;
      drainCntQ <= drainCntD;
      timeoutQ  <= timeoutD;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int unsigned RegW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [RegW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic            ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM, HaltD;
  logic            StallF, StallD, StallE, StallM, FlushD, FlushE, Halted, MemTimeout;
  logic [1:0]      ForwardAE, ForwardBE;

  // {StallF,StallD,StallE,StallM}_{FlushD,FlushE}_{FwdA}_{FwdB}_{Halted}_{MemTimeout}
  logic [11:0]     outs;
  assign outs = {StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE,
                 Halted, MemTimeout};

  int errCnt = 0;
  int chkCnt = 0;

  pipeline_hazard_ctrl #(
    .REG_W       (RegW),
    .CNT_W       (8),
    .MEM_TIMEOUT (8),
    .DRAIN_CYCLES(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .ResultSrcE0(ResultSrcE0),
    .RdM        (RdM),
    .RegWriteM  (RegWriteM),
    .RdW        (RdW),
    .RegWriteW  (RegWriteW),
    .PCSrcE     (PCSrcE),
    .MemReqM    (MemReqM),
    .MemReadyM  (MemReadyM),
    .HaltD      (HaltD),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .Halted     (Halted),
    .MemTimeout (MemTimeout)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [11:0] got, input logic [11:0] want);
    chkCnt++;
    if (got !== want) begin
      errCnt++;
      $display("FAIL %s: got %b want %b", tag, got, want);
    end
  endtask

  task automatic setIdle();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE0 = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0;
    MemReqM = 1'b0; MemReadyM = 1'b0; HaltD = 1'b0;
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    setIdle();
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held two cycles.
    reset = 1'b1;
    setIdle();
    tick();
    checkEq("reset_c1", outs, 12'b0000_11_00_00_0_0);
    tick();
    checkEq("reset_c2", outs, 12'b0000_11_00_00_0_0);
    reset = 1'b0;
    #1;
    checkEq("post_reset", outs, 12'b0000_00_00_00_0_0);

    // Forwarding.
    Rs1E = 4'd3; Rs2E = 4'd3; RdM = 4'd3; RegWriteM = 1'b1; RdW = 4'd3; RegWriteW = 1'b1;
    #1 checkEq("fwd_m", outs, 12'b0000_00_10_10_0_0);
    RegWriteM = 1'b0;
    #1 checkEq("fwd_w", outs, 12'b0000_00_01_01_0_0);
    RdM = 4'd0; RdW = 4'd0; RegWriteM = 1'b1; Rs1E = 4'd0; Rs2E = 4'd0;
    #1 checkEq("fwd_r0", outs, 12'b0000_00_00_00_0_0);
    Rs1E = 4'd3; Rs2E = 4'd9; RdM = 4'd3; RdW = 4'd9;
    #1 checkEq("fwd_mix", outs, 12'b0000_00_10_01_0_0);
    RdW = 4'd3;
    #1 checkEq("fwd_a_mprio", outs, 12'b0000_00_10_00_0_0);
    setIdle();

    // Load-use vs branch.
    ResultSrcE0 = 1'b1; RdE = 4'd5; Rs2D = 4'd5;
    #1 checkEq("lw_rs2", outs, 12'b1100_01_00_00_0_0);
    PCSrcE = 1'b1;
    #1 checkEq("br_over_lw", outs, 12'b0000_11_00_00_0_0);
    PCSrcE = 1'b0; RdE = 4'd0; Rs2D = 4'd0; Rs1D = 4'd0;
    #1 checkEq("lw_r0", outs, 12'b0000_00_00_00_0_0);
    RdE = 4'd6; Rs1D = 4'd6; HaltD = 1'b1;
    #1 checkEq("lw_over_halt", outs, 12'b1100_01_00_00_0_0);
    tick();
    setIdle();
    #1 checkEq("lw_halt_not_taken", outs, 12'b0000_00_00_00_0_0);
    PCSrcE = 1'b1; HaltD = 1'b1;
    #1 checkEq("br_over_halt", outs, 12'b0000_11_00_00_0_0);
    tick();
    setIdle();
    #1 checkEq("br_halt_not_taken", outs, 12'b0000_00_00_00_0_0);

    // Memory wait of 4 cycles; a redirect in the same cycle is held.
    MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
    #1 checkEq("mem_over_br", outs, 12'b1111_00_00_00_0_0);
    PCSrcE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 checkEq($sformatf("mem_wait_%0d", i), outs, 12'b1111_00_00_00_0_0);
      tick();
    end
    MemReadyM = 1'b1;
    #1 checkEq("mem_ready", outs, 12'b0000_00_00_00_0_0);
    tick();
    setIdle();
    #1 checkEq("mem_no_timeout", outs, 12'b0000_00_00_00_0_0);

    // Timeout after 8 consecutive stall cycles.
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1 checkEq($sformatf("to_wait_%0d", i), outs, 12'b1111_00_00_00_0_0);
      tick();
    end
    #1 checkEq("timeout_hit", outs, 12'b1111_00_00_00_1_1);
    setIdle();
    tick();
    tick();
    #1 checkEq("timeout_sticky", outs, 12'b1111_00_00_00_1_1);
    reset = 1'b1;
    #1 checkEq("timeout_in_reset", outs, 12'b0000_11_00_00_0_1);
    tick();
    checkEq("timeout_cleared", outs, 12'b0000_11_00_00_0_0);
    reset = 1'b0;
    #1 checkEq("timeout_post_reset", outs, 12'b0000_00_00_00_0_0);

    // Halt: 1 + 3 drain cycles with StallF/FlushD, then halted.
    HaltD = 1'b1;
    #1 checkEq("halt_accept", outs, 12'b1000_10_00_00_0_0);
    tick();
    HaltD = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 checkEq($sformatf("drain_%0d", i), outs, 12'b1000_10_00_00_0_0);
      tick();
    end
    #1 checkEq("halted", outs, 12'b1111_00_00_00_1_0);
    Rs1E = 4'd3; RdM = 4'd3; RegWriteM = 1'b1;
    #1 checkEq("halted_fwd", outs, 12'b1111_00_10_00_1_0);
    setIdle();
    tick();
    #1 checkEq("halted_stays", outs, 12'b1111_00_00_00_1_0);
    doReset();
    checkEq("halt_reset", outs, 12'b0000_00_00_00_0_0);

    // Halt with a 2-cycle memory wait inside drain: Halted two cycles later.
    HaltD = 1'b1;
    #1 checkEq("halt2_accept", outs, 12'b1000_10_00_00_0_0);
    tick();
    HaltD = 1'b0;
    #1 checkEq("halt2_drain0", outs, 12'b1000_10_00_00_0_0);
    tick();
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 checkEq($sformatf("drain_mem_%0d", i), outs & 12'b1111_01_11_11_1_1,
                 12'b1111_00_00_00_0_0);
      tick();
    end
    MemReqM = 1'b0;
    for (int i = 1; i < 3; i++) begin
      #1 checkEq($sformatf("halt2_drain%0d", i), outs, 12'b1000_10_00_00_0_0);
      tick();
    end
    #1 checkEq("halt2_halted", outs, 12'b1111_00_00_00_1_0);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
